// File: rtl/rdp_systolic_join_if.sv
// Handshake bundle for rdp_systolic_join: k target slots, shared c operand, and per-group initiators.
// The slave modport is the join block; the master modport is the environment around it.
interface rdp_systolic_join_if #(
    parameter int GROUPS = 2,
    parameter int FANIN  = 2
);
    logic [GROUPS*FANIN-1:0] t_k_req;
    logic [GROUPS*FANIN-1:0] t_k_ack;
    logic                    t_c_req;
    logic                    t_c_ack;
    logic [GROUPS-1:0]       i_req;
    logic [GROUPS-1:0]       i_ack;

    modport slave (
        input  t_k_req, t_c_req, i_ack,
        output t_k_ack, t_c_ack, i_req
    );

    modport master (
        output t_k_req, t_c_req, i_ack,
        input  t_k_ack, t_c_ack, i_req
    );
endinterface

// File: rtl/rdp_systolic_join.sv
// Joins FANIN k tokens per group with one shared c token and fires each group once per c operand.
// Optional fire/c counters are built when RDP_SYSTOLIC_JOIN_CNT_EN is defined.
module rdp_systolic_join #(
    parameter int GROUPS = 2,
    parameter int FANIN  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    rdp_systolic_join_if.slave    bus
`ifdef RDP_SYSTOLIC_JOIN_CNT_EN
    ,
    output logic [GROUPS*16-1:0]  fire_cnt,
    output logic [15:0]           c_cnt
`endif
);
    localparam int SLOTS = GROUPS * FANIN;

    logic [SLOTS-1:0]  r_held_k;
    logic              r_held_c;
    logic [GROUPS-1:0] r_done;

    logic [GROUPS-1:0] w_full;
    logic [GROUPS-1:0] w_i_req;
    logic [GROUPS-1:0] w_fire;
    logic [SLOTS-1:0]  w_k_take;
    logic [SLOTS-1:0]  w_k_clr;
    logic              w_c_take;
    logic              w_all_done;

    // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        w_full  = '0;
        w_k_clr = '0;
        for (int g = 0; g < GROUPS; g++) begin
            w_full[g] = &r_held_k[g*FANIN +: FANIN];
        end
        for (int j = 0; j < SLOTS; j++) begin
            w_k_clr[j] = w_fire[j / FANIN];
        end
    end

    // done[g] blocks a group that already fired from pairing its next k tokens with the old c.
    assign w_i_req    = {GROUPS{r_held_c}} & w_full & ~r_done;
    assign w_fire     = w_i_req & bus.i_ack;
    assign w_all_done = &(r_done | w_fire);
    assign w_k_take   = bus.t_k_req & ~r_held_k;
    assign w_c_take   = bus.t_c_req & ~r_held_c;

    assign bus.i_req   = w_i_req;
    assign bus.t_k_ack = ~r_held_k;
    assign bus.t_c_ack = ~r_held_c;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_held_k <= '0;
            r_held_c <= 1'b0;
            r_done   <= '0;
        end else begin
            // A fired slot is cleared here and can only be re-taken once its ack rises next cycle.
            r_held_k <= (r_held_k | w_k_take) & ~w_k_clr;
            if (w_all_done) begin
                r_held_c <= 1'b0;
                r_done   <= '0;
            end else begin
                r_held_c <= r_held_c | w_c_take;
                r_done   <= r_done | w_fire;
            end
        end
    end

`ifdef RDP_SYSTOLIC_JOIN_CNT_EN
    logic [15:0] r_fire_cnt [GROUPS];
    logic [15:0] r_c_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int g = 0; g < GROUPS; g++) begin
                r_fire_cnt[g] <= '0;
            end
            r_c_cnt <= '0;
        end else begin
            for (int g = 0; g < GROUPS; g++) begin
                r_fire_cnt[g] <= r_fire_cnt[g] + 16'(w_fire[g]);
            end
            r_c_cnt <= r_c_cnt + 16'(w_all_done);
        end
    end

    always_comb begin
        fire_cnt = '0;
        for (int g = 0; g < GROUPS; g++) begin
            fire_cnt[g*16 +: 16] = r_fire_cnt[g];
        end
    end

    assign c_cnt = r_c_cnt;
`endif

endmodule

// File: tb/tb_rdp_systolic_join.sv
// Self-checking bench for rdp_systolic_join (GROUPS=2, FANIN=2): directed vector table,
// reset corner cases, then random traffic against a token-counting reference model.
module tb_rdp_systolic_join;
    localparam int G = 2;
    localparam int F = 2;
    localparam int S = G * F;

    logic clk = 1'b0;
    logic reset;

    rdp_systolic_join_if #(.GROUPS(G), .FANIN(F)) bus ();

`ifdef RDP_SYSTOLIC_JOIN_CNT_EN
    logic [G*16-1:0] fire_cnt;
    logic [15:0]     c_cnt;
`endif

    rdp_systolic_join #(.GROUPS(G), .FANIN(F)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave)
`ifdef RDP_SYSTOLIC_JOIN_CNT_EN
        ,
        .fire_cnt (fire_cnt),
        .c_cnt    (c_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tokens held per slot, c operands accepted/completed, fires per group.
    int tok [S];
    int fires [G];
    int c_acc;
    int c_done;
    logic [G-1:0] m_ireq;
    logic [S-1:0] m_kack;
    logic         m_cack;

    function automatic void model_reset();
        for (int j = 0; j < S; j++) tok[j] = 0;
        for (int g = 0; g < G; g++) fires[g] = 0;
        c_acc  = 0;
        c_done = 0;
    endfunction

    function automatic void model_eval();
        bool_t_dummy: begin end
        m_cack = (c_acc == c_done);
        for (int j = 0; j < S; j++) m_kack[j] = (tok[j] == 0);
        for (int g = 0; g < G; g++) begin
            logic all_tok;
            all_tok = 1'b1;
            for (int k = 0; k < F; k++) if (tok[g*F + k] == 0) all_tok = 1'b0;
            m_ireq[g] = (c_acc > c_done) && all_tok && (fires[g] == c_done);
        end
    endfunction

    function automatic void model_update(input logic [S-1:0] kreq, input logic creq, input logic [G-1:0] iack);
        logic [G-1:0] fire;
        int           n_next;
        model_eval();
        fire = m_ireq & iack;
        for (int j = 0; j < S; j++) begin
            if (kreq[j] && m_kack[j]) tok[j]++;
            if (fire[j / F]) tok[j]--;
        end
        if (creq && m_cack) c_acc++;
        n_next = 0;
        for (int g = 0; g < G; g++) begin
            if (fire[g]) fires[g]++;
            if (fires[g] == c_done + 1) n_next++;
        end
        if (n_next == G) c_done++;
    endfunction

    task automatic compare_model(input string tag);
        model_eval();
        check({tag, ".i_req"},   32'(bus.i_req),   32'(m_ireq));
        check({tag, ".t_k_ack"}, 32'(bus.t_k_ack), 32'(m_kack));
        check({tag, ".t_c_ack"}, 32'(bus.t_c_ack), 32'(m_cack));
`ifdef RDP_SYSTOLIC_JOIN_CNT_EN
        check({tag, ".fire_cnt"}, 32'(fire_cnt), {16'(fires[1]), 16'(fires[0])});
        check({tag, ".c_cnt"},    32'(c_cnt),    32'(16'(c_done)));
`endif
    endtask

    // Drive inputs just after a falling edge, clock once, compare at the next falling edge.
    task automatic step(input logic [S-1:0] kreq, input logic creq, input logic [G-1:0] iack,
                        input string tag);
        bus.t_k_req = kreq;
        bus.t_c_req = creq;
        bus.i_ack   = iack;
        @(posedge clk);
        model_update(kreq, creq, iack);
        @(negedge clk);
        compare_model(tag);
    endtask

    typedef struct {
        logic [S-1:0] kreq;
        logic         creq;
        logic [G-1:0] iack;
        logic [G-1:0] exp_ireq;
        logic [S-1:0] exp_kack;
        logic         exp_cack;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{4'b0011, 1'b1, 2'b00, 2'b01, 4'b1100, 1'b0};
        vecs[1] = '{4'b0000, 1'b0, 2'b01, 2'b00, 4'b1111, 1'b0};
        vecs[2] = '{4'b0011, 1'b0, 2'b00, 2'b00, 4'b1100, 1'b0};
        vecs[3] = '{4'b1100, 1'b0, 2'b00, 2'b10, 4'b0000, 1'b0};
        vecs[4] = '{4'b0000, 1'b1, 2'b01, 2'b10, 4'b0000, 1'b0};
        vecs[5] = '{4'b0000, 1'b0, 2'b10, 2'b00, 4'b1100, 1'b1};
        vecs[6] = '{4'b0000, 1'b1, 2'b00, 2'b01, 4'b1100, 1'b0};
        vecs[7] = '{4'b1100, 1'b0, 2'b00, 2'b11, 4'b0000, 1'b0};
        vecs[8] = '{4'b0000, 1'b0, 2'b11, 2'b00, 4'b1111, 1'b1};
        vecs[9] = '{4'b0000, 1'b0, 2'b11, 2'b00, 4'b1111, 1'b1};

        reset       = 1'b1;
        bus.t_k_req = '0;
        bus.t_c_req = 1'b0;
        bus.i_ack   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset.i_req",   32'(bus.i_req),   32'h0);
        check("reset.t_k_ack", 32'(bus.t_k_ack), 32'hF);
        check("reset.t_c_ack", 32'(bus.t_c_ack), 32'h1);

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].kreq, vecs[i].creq, vecs[i].iack, $sformatf("vec%0d.model", i));
            check($sformatf("vec%0d.i_req", i),   32'(bus.i_req),   32'(vecs[i].exp_ireq));
            check($sformatf("vec%0d.t_k_ack", i), 32'(bus.t_k_ack), 32'(vecs[i].exp_kack));
            check($sformatf("vec%0d.t_c_ack", i), 32'(bus.t_c_ack), 32'(vecs[i].exp_cack));
        end

`ifdef RDP_SYSTOLIC_JOIN_CNT_EN
        check("vec.fire_cnt", 32'(fire_cnt), {16'd2, 16'd2});
        check("vec.c_cnt",    32'(c_cnt),    32'd2);
`endif

        // Load every slot and c, then assert reset between edges while both groups request.
        step(4'b1111, 1'b1, 2'b00, "pre_rst");
        check("pre_rst.i_req", 32'(bus.i_req), 32'h3);
        #2 reset = 1'b1;
        #1;
        check("async_rst.i_req",   32'(bus.i_req),   32'h0);
        check("async_rst.t_k_ack", 32'(bus.t_k_ack), 32'hF);
        check("async_rst.t_c_ack", 32'(bus.t_c_ack), 32'h1);
`ifdef RDP_SYSTOLIC_JOIN_CNT_EN
        check("async_rst.c_cnt", 32'(c_cnt), 32'h0);
`endif
        bus.i_ack = 2'b11;
        model_reset();
        @(negedge clk);
        check("in_rst.i_req", 32'(bus.i_req), 32'h0);
        reset = 1'b0;
        step(4'b0000, 1'b0, 2'b11, "post_rst");
        check("post_rst.i_req", 32'(bus.i_req), 32'h0);

        // Random traffic; i_ack is biased high so fires are frequent.
        for (int n = 0; n < 3000; n++) begin
            logic [G-1:0] ack;
            ack = 2'($urandom) | 2'($urandom);
            step(4'($urandom), 1'($urandom), ack, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rdp_systolic_join.md
RDP_SYSTOLIC_JOIN -- requirements
Module: rdp_systolic_join

Interface
REQ-001 The block SHALL provide parameter GROUPS, default 2, number of initiator channels (legal 1..8).
REQ-002 The block SHALL provide parameter FANIN, default 2, number of k target channels joined per group (legal 1..8).
REQ-003 The block SHALL provide port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL provide port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL provide port t_k_req  input  GROUPS*FANIN  k target request; slot j belongs to group j/FANIN.
REQ-006 The block SHALL provide port t_k_ack  output  GROUPS*FANIN  k target acknowledge.
REQ-007 The block SHALL provide port t_c_req  input  1  shared c operand request.
REQ-008 The block SHALL provide port t_c_ack  output  1  shared c operand acknowledge.
REQ-009 The block SHALL provide port i_req  output  GROUPS  initiator request per group.
REQ-010 The block SHALL provide port i_ack  input  GROUPS  initiator acknowledge per group.

Function
REQ-011 The block SHALL hold one token flag per k slot (held_k), one c flag (held_c) and one fired flag per group (done); every output is a function of these registers only, plus the same-cycle inputs given in REQ-013.
REQ-012 The block SHALL drive t_k_ack[j] = ~held_k[j] and t_c_ack = ~held_c.
REQ-013 A transfer on a target channel SHALL occur in a cycle with req & ack both high; held flag sets at that edge; ack drops next cycle.
REQ-014 The block SHALL drive i_req[g] = held_c & (all FANIN held_k of group g) & ~done[g]; capture-to-i_req latency is 1 cycle.
REQ-015 Once high, i_req[g] SHALL stay high until the cycle with i_ack[g] high (stable until ack); i_ack[g] with i_req[g] low is ignored.
REQ-016 A fire of group g (i_req[g] & i_ack[g]) SHALL clear all held_k of group g and set done[g] at that edge.
REQ-017 When every done bit is set, counting fires in the current cycle, held_c and all done bits SHALL clear at that edge; the next c token is then accepted.
REQ-018 k tokens for the next c operand SHALL be accepted for a group as soon as that group has fired; done[g] keeps them from pairing with the old c.
REQ-019 Groups SHALL fire independently and simultaneously; with all groups firing together, held_c clears in that same cycle.
REQ-020 A slot freed by a fire SHALL re-accept no earlier than the next cycle; the sustained rate is one fire per group every 2 cycles.
REQ-021 Tokens SHALL never be dropped or duplicated; a req held low while its ack is high leaves state unchanged.

Reset
REQ-022 Assertion of reset SHALL immediately clear held_k, held_c, done and counters; i_req goes to 0 and t_k_ack and t_c_ack go to all-ones.
REQ-023 Reset mid-transaction SHALL discard all held tokens with no fire generated; operation resumes on the first edge after deassertion.

Configuration
REQ-024 With macro RDP_SYSTOLIC_JOIN_CNT_EN defined, the block SHALL add output fire_cnt (GROUPS*16 bits, 16-bit per-group fire count) and output c_cnt (16 bits, count of completed c operands), both wrapping 65535->0 and reset to 0.
REQ-025 Without RDP_SYSTOLIC_JOIN_CNT_EN, the fire_cnt and c_cnt ports and counter logic SHALL be absent; handshake behaviour is identical either way.

Verification (GROUPS=2, FANIN=2)
REQ-026 Reset released, all req low -> i_req=2'b00, t_k_ack=4'b1111, t_c_ack=1.
REQ-027 t_k_req=4'b0011 and t_c_req=1 in cycle 0 -> in cycle 1: i_req=2'b01, t_k_ack=4'b1100, t_c_ack=0; i_ack=2'b01 in cycle 1 -> in cycle 2: i_req=0, t_k_ack[1:0]=2'b11, t_c_ack still 0.
REQ-028 Group 0 fired, new t_k_req[1:0]=2'b11 accepted while group 1 pending -> i_req[0] stays 0 until group 1 fires and a new c is accepted.
REQ-029 All slots and c held, i_ack=2'b11 in cycle n -> in cycle n+1: t_c_ack=1 and t_k_ack=4'b1111; with counters enabled, fire_cnt={16'd1,16'd1} and c_cnt=1.
REQ-030 Reset asserted asynchronously between clock edges while i_req=2'b11 -> i_req drops to 0 before the next edge; no counter increments.
REQ-031 With counters enabled, 65536 completed c operands -> c_cnt=0 and each group's fire_cnt=0.
